// File: rtl/dm_sized_if.sv
// Request/response bundle between the MEM stage (master) and dm_sized (slave).
interface dm_sized_if #(
  parameter int unsigned AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_sized.sv
// Byte-addressed big-endian data memory with byte/half/word access, error checks,
// single-cycle registered responses and a word-per-cycle zero clear after reset.
module dm_sized #(
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 32
) (
  input logic     clk,
  input logic     rst,
  dm_sized_if.slave bus
);
  localparam int unsigned IDXW  = $clog2(DEPTH);
  localparam int unsigned WORDS = DEPTH / 4;
  localparam int unsigned CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {CLEAR, RUN} stateT;

  stateT           state, stateNext;
  logic [CW-1:0]   clrCnt, clrCntNext;
  logic            readyQ, readyNext;
  logic            rspValidQ, rspValidNext;
  logic [31:0]     rdataQ, rdataNext;
  logic            errQ, errNext;

  // Word-organised storage; byte offset 0 lives in bits [31:24].
  logic [31:0]     mem [WORDS];

  logic            accept;
  logic            reqErr;
  logic [1:0]      byteOff;
  logic [CW-1:0]   wordIdx;
  logic [3:0]      wMask;
  logic [31:0]     wWord;
  logic [31:0]     shifted;
  logic [31:0]     loadVal;

  assign accept  = bus.req_valid && readyQ;
  assign byteOff = bus.req_addr[1:0];
  assign wordIdx = CW'(bus.req_addr >> 2);

  // Request legality: size, alignment and range.
  always_comb begin
    reqErr = 1'b0;
    if (bus.req_size == 2'b11)                              reqErr = 1'b1;
    if (bus.req_size == 2'b01 && byteOff[0])                reqErr = 1'b1;
    if (bus.req_size == 2'b10 && byteOff != 2'b00)          reqErr = 1'b1;
    if ((bus.req_addr >> IDXW) != '0)                       reqErr = 1'b1;
  end

  // Store lane enables and lane-replicated data.
  always_comb begin
    wMask = 4'b0000;
    wWord = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        wMask = 4'b1000 >> byteOff;
        wWord = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        wMask = byteOff[1] ? 4'b0011 : 4'b1100;
        wWord = {2{bus.req_wdata[15:0]}};
      end
      2'b10:   wMask = 4'b1111;
      default: wMask = 4'b0000;
    endcase
  end

  // Load: shift the addressed byte/half to the top, then extend.
  always_comb begin
    shifted = mem[wordIdx] << {byteOff, 3'b000};
    case (bus.req_size)
      2'b00:   loadVal = bus.req_unsigned ? {24'h0, shifted[31:24]}
                                          : {{24{shifted[31]}}, shifted[31:24]};
      2'b01:   loadVal = bus.req_unsigned ? {16'h0, shifted[31:16]}
                                          : {{16{shifted[31]}}, shifted[31:16]};
      default: loadVal = mem[wordIdx];
    endcase
  end

  always_comb begin
    stateNext    = state;
    clrCntNext   = clrCnt;
    rspValidNext = 1'b0;
    rdataNext    = 32'h0;
    errNext      = 1'b0;
    case (state)
      CLEAR: begin
        if (clrCnt == CW'(WORDS - 1)) begin
          stateNext  = RUN;
          clrCntNext = '0;
        end else begin
          clrCntNext = clrCnt + CW'(1);
        end
      end
      RUN: begin
        if (accept) begin
          rspValidNext = 1'b1;
          errNext      = reqErr;
          if (!reqErr && !bus.req_write) rdataNext = loadVal;
        end
      end
      default: stateNext = CLEAR;
    endcase
    readyNext = (stateNext == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clrCnt    <= '0;
      readyQ    <= 1'b0;
      rspValidQ <= 1'b0;
      rdataQ    <= 32'h0;
      errQ      <= 1'b0;
    end else begin
      state     <= stateNext;
      clrCnt    <= clrCntNext;
      readyQ    <= readyNext;
      rspValidQ <= rspValidNext;
      rdataQ    <= rdataNext;
      errQ      <= errNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clrCnt] <= 32'h0;
      end else if (accept && bus.req_write && !reqErr) begin
        for (int i = 0; i < 4; i++) begin
          if (wMask[i]) mem[wordIdx][8*i +: 8] <= wWord[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready = readyQ;
  assign bus.rsp_valid = rspValidQ;
  assign bus.rsp_rdata = rdataQ;
  assign bus.rsp_err   = errQ;
endmodule

// File: tb/tb_dm_sized.sv
// Directed bench for dm_sized: byte-array model checked every cycle, plus literal expectations.
module tb_dm_sized;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dm_sized_if #(.AW(AW)) bus();
  dm_sized #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int passed = 0;
  int total  = 0;

  logic [7:0]  modelMem [DEPTH];
  int          clearLeft = 0;
  logic        modelOn   = 1'b0;
  logic        expReady  = 1'b0;
  logic        expValid  = 1'b0;
  logic        expErr    = 1'b0;
  logic [31:0] expData   = 32'h0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Spec-level access model over a flat byte array.
  task automatic modelAccess(input logic w, input logic [1:0] s, input logic u,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic err, output logic [31:0] data);
    int n;
    n    = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    err  = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0) || (a >= DEPTH);
    data = 32'h0;
    if (!err) begin
      if (w) begin
        for (int i = 0; i < n; i++) modelMem[a + i] = d[8*(n-1-i) +: 8];
      end else begin
        for (int i = 0; i < n; i++) data = (data << 8) | 32'(modelMem[a + i]);
        if (!u && n < 4 && data[8*n-1]) data = data | ~((32'h1 << (8*n)) - 32'h1);
      end
    end
  endtask

  // Advance one edge and update the model with what that edge did.
  task automatic tick();
    logic r, v, w, u;
    logic [1:0] s;
    logic [31:0] a, d;
    r = rst; v = bus.req_valid; w = bus.req_write; s = bus.req_size;
    u = bus.req_unsigned; a = bus.req_addr; d = bus.req_wdata;
    @(posedge clk);
    #1;
    expValid = 1'b0; expData = 32'h0; expErr = 1'b0;
    if (r) begin
      modelOn = 1'b1;
      clearLeft = DEPTH / 4;
      foreach (modelMem[i]) modelMem[i] = 8'h0;
      expReady = 1'b0;
    end else if (clearLeft > 0) begin
      clearLeft--;
      expReady = (clearLeft == 0);
    end else begin
      expReady = 1'b1;
      if (v) begin
        expValid = 1'b1;
        modelAccess(w, s, u, a, d, expErr, expData);
      end
    end
  endtask

  always @(negedge clk) begin
    if (modelOn) begin
      check("req_ready", 32'(bus.req_ready), 32'(expReady));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(expValid));
      check("rsp_rdata", bus.rsp_rdata, expData);
      check("rsp_err",   32'(bus.rsp_err),   32'(expErr));
    end
  end

  task automatic setReq(input logic v, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = v; bus.req_write = w; bus.req_size = s;
    bus.req_unsigned = u; bus.req_addr = a; bus.req_wdata = d;
  endtask

  task automatic req(input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] d);
    setReq(1'b1, w, s, u, a, d);
    tick();
    setReq(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic load(input string name, input logic [1:0] s, input logic u,
                      input logic [31:0] a, input logic [31:0] exp, input logic expE);
    req(1'b0, s, u, a, 32'h0);
    check({name, "_valid"}, 32'(bus.rsp_valid), 32'h1);
    check({name, "_data"}, bus.rsp_rdata, exp);
    check({name, "_err"}, 32'(bus.rsp_err), 32'(expE));
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    setReq(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (3) tick();
    check("reset_ready", 32'(bus.req_ready), 32'h0);
    check("reset_valid", 32'(bus.rsp_valid), 32'h0);
    rst = 1'b0;
    waitReady(n);
    check("clear_len", 32'(n), 32'd32);

    load("ldw0",   2'd2, 1'b0, 32'd0,   32'h0, 1'b0);
    load("ldw60",  2'd2, 1'b0, 32'd60,  32'h0, 1'b0);
    load("ldw124", 2'd2, 1'b0, 32'd124, 32'h0, 1'b0);

    req(1'b1, 2'd2, 1'b0, 32'd8, 32'hDEADBEEF);
    check("stw_data", bus.rsp_rdata, 32'h0);
    load("ldb8",  2'd0, 1'b1, 32'd8,  32'h000000DE, 1'b0);
    load("ldb9",  2'd0, 1'b1, 32'd9,  32'h000000AD, 1'b0);
    load("ldb10", 2'd0, 1'b1, 32'd10, 32'h000000BE, 1'b0);
    load("ldb11", 2'd0, 1'b1, 32'd11, 32'h000000EF, 1'b0);
    load("ldbs8", 2'd0, 1'b0, 32'd8,  32'hFFFFFFDE, 1'b0);

    req(1'b1, 2'd1, 1'b0, 32'd20, 32'h00008001);
    load("ldw20",  2'd2, 1'b0, 32'd20, 32'h80010000, 1'b0);
    load("ldhs20", 2'd1, 1'b0, 32'd20, 32'hFFFF8001, 1'b0);
    load("ldhu20", 2'd1, 1'b1, 32'd20, 32'h00008001, 1'b0);

    load("err_ldw6", 2'd2, 1'b0, 32'd6, 32'h0, 1'b1);
    req(1'b1, 2'd1, 1'b0, 32'd3, 32'h0000ABCD);
    check("err_sth3", 32'(bus.rsp_err), 32'h1);
    req(1'b1, 2'd2, 1'b0, 32'd128, 32'h12345678);
    check("err_stw128", 32'(bus.rsp_err), 32'h1);
    req(1'b1, 2'd3, 1'b0, 32'd8, 32'h11111111);
    check("err_size3_st", 32'(bus.rsp_err), 32'h1);
    load("err_size3_ld", 2'd3, 1'b0, 32'd0, 32'h0, 1'b1);
    load("err_hiaddr", 2'd0, 1'b1, 32'h0001_0008, 32'h0, 1'b1);
    load("reread0", 2'd2, 1'b0, 32'd0, 32'h0, 1'b0);
    load("reread4", 2'd2, 1'b0, 32'd4, 32'h0, 1'b0);
    load("reread8", 2'd2, 1'b0, 32'd8, 32'hDEADBEEF, 1'b0);

    req(1'b1, 2'd0, 1'b0, 32'd40, 32'h0000005A);
    check("b2b_st_valid", 32'(bus.rsp_valid), 32'h1);
    load("b2b_ld40", 2'd0, 1'b1, 32'd40, 32'h0000005A, 1'b0);

    req(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
    setReq(1'b1, 1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
    rst = 1'b1;
    tick();
    check("rst_drop_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    setReq(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    repeat (10) tick();
    check("midclear_ready", 32'(bus.req_ready), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    waitReady(n);
    check("reclear_len", 32'(n), 32'd32);

    load("post_ldw8",  2'd2, 1'b0, 32'd8,  32'h0, 1'b0);
    load("post_ldw20", 2'd2, 1'b0, 32'd20, 32'h0, 1'b0);
    load("post_ldb40", 2'd0, 1'b1, 32'd40, 32'h0, 1'b0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dm_sized.md
Name: dm_sized

Overview:
- Parametrised, single-port, byte-addressed data memory. Successor to the fixed 128-byte word-only DM.
- Adds byte, halfword and word accesses, with signed or unsigned load extension.
- Detects misaligned and out-of-range accesses, returns registered responses through a valid/ready request port, and clears itself to zero after reset.
- Sits between the CPU's MEM stage and the data array. Byte order is big-endian: the lowest address holds the MSB.

Parameters:
- DEPTH, 128, memory size in bytes; must be a power of two, >= 4.
- AW, 32, request address width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block accepts a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  AW  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  response present; exactly one cycle per accepted request.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_err  output  1  access rejected.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high; it is sampled only at posedge clk.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=CLEAR, clear counter=0.
- CLEAR state:
  - Writes 32'h0 to one aligned word per cycle, at byte address 4*counter.
  - Lasts DEPTH/4 cycles; req_ready=0 throughout. Then moves to RUN.
  - rst asserted in any state (including mid-CLEAR) restarts CLEAR from counter 0.
  - Any in-flight response is dropped: rsp_valid=0 on the next edge.
- RUN state:
  - req_ready=1 every cycle. A request is accepted on a posedge where req_valid && req_ready.
  - Fixed latency: request accepted at edge N produces rsp_valid=1 for exactly the cycle following edge N.
  - With no accept, rsp_valid=0 and rsp_rdata/rsp_err return to 0.
  - Back-to-back accepts are allowed every cycle.
- Error check (combinational on the request); any one sets rsp_err=1, rsp_rdata=0, and leaves memory unchanged:
  - req_size==11;
  - halfword with addr[0]!=0;
  - word with addr[1:0]!=0;
  - req_addr >= DEPTH, including any nonzero bit above log2(DEPTH).
- Store, at address a:
  - byte: mem[a]=wdata[7:0].
  - half: mem[a]=wdata[15:8], mem[a+1]=wdata[7:0].
  - word: mem[a..a+3]=wdata[31:24], [23:16], [15:8], [7:0].
  - Response: rsp_err=0, rsp_rdata=0.
- Load, at address a:
  - byte: value=mem[a].
  - half: value={mem[a],mem[a+1]}.
  - word: value={mem[a],mem[a+1],mem[a+2],mem[a+3]}.
  - Byte/half results are extended to 32 bits per req_unsigned; word loads ignore req_unsigned.
- Ordering:
  - A store accepted at edge N is visible to a load accepted at edge N+1.
  - Single port, so there is no same-cycle read/write conflict.
- req_valid while req_ready=0 is ignored; no queuing. The requester holds its request until req_ready=1.

Test Plan:
- Reset held 3 cycles, then released -> req_ready=0 for exactly DEPTH/4=32 cycles, then 1. Word loads at 0, 60 and 124 return 0, rsp_err=0.
- Word store 32'hDEADBEEF at 8, then byte loads at 8..11 -> 0xDE, 0xAD, 0xBE, 0xEF in rsp_rdata[7:0].
  - Signed byte load at 8 -> 32'hFFFFFFDE.
  - Unsigned byte load at 8 -> 32'h000000DE.
- Half store 16'h8001 at 20 (word at 20 previously 0) -> word load at 20 returns 32'h80010000. Signed half load at 20 -> 32'hFFFF8001.
- Error cases, each -> rsp_err=1, rsp_rdata=0, memory unchanged (verified by re-read):
  - word load at 6;
  - half store at 3;
  - word store at 128;
  - req_size=11.
- Back-to-back: store byte 0x5A at 40, then load byte at 40 next cycle -> rsp_valid on two consecutive cycles, load returns 0x5A.
- rst asserted mid-CLEAR (cycle 10) and after data written in RUN -> CLEAR restarts. req_ready=0 for a full 32 cycles, rsp_valid=0 on the edge after rst, and all previously written data reads 0.
